// File: rtl/dram_arb.sv
// Two-requester arbiter in front of a single DRAM controller port.
// One transaction (command plus its write or read burst) owns the downstream port at a time.
module dram_arb #(
  parameter int RR_EN = 1
) (
  input  logic        clk_core,
  input  logic        reset_n,

  input  logic        m0_cvalid,
  output logic        m0_cready,
  input  logic        m0_cmd,
  input  logic [27:2] m0_addr,
  input  logic        m0_wvalid,
  output logic        m0_wready,
  input  logic        m0_wlast,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wmask,
  output logic        m0_rvalid,
  input  logic        m0_rready,
  output logic        m0_rlast,
  output logic [31:0] m0_rdata,

  input  logic        m1_cvalid,
  output logic        m1_cready,
  input  logic        m1_cmd,
  input  logic [27:2] m1_addr,
  input  logic        m1_wvalid,
  output logic        m1_wready,
  input  logic        m1_wlast,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wmask,
  output logic        m1_rvalid,
  input  logic        m1_rready,
  output logic        m1_rlast,
  output logic [31:0] m1_rdata,

  output logic        bmain_cvalid_dctl,
  input  logic        dctl_cready,
  output logic        bmain_cmd,
  output logic [27:2] bmain_addr,

  output logic        bmain_wvalid_dctl,
  input  logic        dctl_wready,
  output logic        bmain_wlast,
  output logic [31:0] bmain_wdata,
  output logic [3:0]  bmain_wmask,

  input  logic        dctl_rvalid,
  output logic        bmain_rready_dctl,
  input  logic        dctl_rlast,
  input  logic [31:0] dctl_rdata,

  output logic [1:0]  arb_grant,
  output logic        arb_busy,
  output logic        arb_error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    WDATA = 2'd2,
    RDATA = 2'd3
  } state_t;

  state_t     state_reg, state_next;
  logic [1:0] grant_reg, grant_next;
  logic       ptr_reg, ptr_next;
  logic       error_reg, error_next;

  // Requester-indexed views of the upstream ports
  logic [1:0]  req_cvalid, req_cmd, req_wvalid, req_wlast, req_rready;
  logic [27:2] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_wmask [2];
  logic [1:0]  cready_vec, wready_vec, rvalid_vec;

  assign req_cvalid   = {m1_cvalid, m0_cvalid};
  assign req_cmd      = {m1_cmd,    m0_cmd};
  assign req_wvalid   = {m1_wvalid, m0_wvalid};
  assign req_wlast    = {m1_wlast,  m0_wlast};
  assign req_rready   = {m1_rready, m0_rready};
  assign req_addr[0]  = m0_addr;
  assign req_addr[1]  = m1_addr;
  assign req_wdata[0] = m0_wdata;
  assign req_wdata[1] = m1_wdata;
  assign req_wmask[0] = m0_wmask;
  assign req_wmask[1] = m1_wmask;

  logic in_cmd, in_wdata, in_rdata;
  logic sel;
  logic cmd_beat, wlast_beat, rlast_beat;
  logic [1:0] winner;

  assign in_cmd   = (state_reg == CMD);
  assign in_wdata = (state_reg == WDATA);
  assign in_rdata = (state_reg == RDATA);

  // grant_reg is one-hot whenever sel is used, so bit 1 is the owner index
  assign sel = grant_reg[1];

  assign cmd_beat   = req_cvalid[sel] & dctl_cready;
  assign wlast_beat = req_wvalid[sel] & dctl_wready & req_wlast[sel];
  assign rlast_beat = dctl_rvalid & req_rready[sel] & dctl_rlast;

  always_comb begin
    winner = 2'b00;
    case (req_cvalid)
      2'b01:   winner = 2'b01;
      2'b10:   winner = 2'b10;
      2'b11:   winner = ((RR_EN != 0) && ptr_reg) ? 2'b10 : 2'b01;
      default: winner = 2'b00;
    endcase
  end

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      grant_reg <= 2'b00;
      ptr_reg   <= 1'b0;
      error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      ptr_reg   <= ptr_next;
      error_reg <= error_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    ptr_next   = ptr_reg;
    error_next = error_reg;

    // The read owner driving write data, or read data with no read open, is a protocol fault
    if ((dctl_rvalid && !in_rdata) || (in_rdata && req_wvalid[sel])) begin
      error_next = 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (|req_cvalid) begin
          state_next = CMD;
          grant_next = winner;
        end
      end
      CMD: begin
        if (cmd_beat) begin
          state_next = req_cmd[sel] ? RDATA : WDATA;
        end
      end
      WDATA: begin
        if (wlast_beat) begin
          state_next = IDLE;
          grant_next = 2'b00;
          ptr_next   = ~sel;
        end
      end
      RDATA: begin
        if (rlast_beat) begin
          state_next = IDLE;
          grant_next = 2'b00;
          ptr_next   = ~sel;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = 2'b00;
      end
    endcase
  end

  // Upstream handshakes: only the owner ever sees ready/valid
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign cready_vec[gi] = in_cmd   & grant_reg[gi] & dctl_cready;
      assign wready_vec[gi] = in_wdata & grant_reg[gi] & dctl_wready;
      assign rvalid_vec[gi] = in_rdata & grant_reg[gi] & dctl_rvalid;
    end
  endgenerate

  assign m0_cready = cready_vec[0];
  assign m1_cready = cready_vec[1];
  assign m0_wready = wready_vec[0];
  assign m1_wready = wready_vec[1];
  assign m0_rvalid = rvalid_vec[0];
  assign m1_rvalid = rvalid_vec[1];

  assign m0_rlast  = in_rdata & dctl_rlast;
  assign m1_rlast  = in_rdata & dctl_rlast;
  assign m0_rdata  = in_rdata ? dctl_rdata : 32'd0;
  assign m1_rdata  = in_rdata ? dctl_rdata : 32'd0;

  assign bmain_cvalid_dctl = in_cmd & req_cvalid[sel];
  assign bmain_cmd         = in_cmd & req_cmd[sel];
  assign bmain_addr        = in_cmd ? req_addr[sel] : 26'd0;

  assign bmain_wvalid_dctl = in_wdata & req_wvalid[sel];
  assign bmain_wlast       = in_wdata & req_wlast[sel];
  assign bmain_wdata       = in_wdata ? req_wdata[sel] : 32'd0;
  assign bmain_wmask       = in_wdata ? req_wmask[sel] : 4'd0;

  assign bmain_rready_dctl = in_rdata & req_rready[sel];

  assign arb_grant = grant_reg;
  assign arb_busy  = (state_reg != IDLE);
  assign arb_error = error_reg;

endmodule

// File: tb/tb_dram_arb.sv
// Bench for dram_arb: a round-robin and a fixed-priority instance share stimulus and
// are each checked every cycle against a transaction-level model, plus directed scenarios.
module tb_dram_arb;

  logic clk_core = 1'b0;
  always #5 clk_core = ~clk_core;

  logic        reset_n;
  logic        m_cvalid [2];
  logic        m_cmd    [2];
  logic [25:0] m_addr   [2];
  logic        m_wvalid [2];
  logic        m_wlast  [2];
  logic [31:0] m_wdata  [2];
  logic [3:0]  m_wmask  [2];
  logic        m_rready [2];
  logic        dctl_cready, dctl_wready, dctl_rvalid, dctl_rlast;
  logic [31:0] dctl_rdata;

  // Outputs indexed [instance][requester]; instance 0 is RR_EN=1, instance 1 is RR_EN=0
  logic        o_cready [2][2];
  logic        o_wready [2][2];
  logic        o_rvalid [2][2];
  logic        o_rlast  [2][2];
  logic [31:0] o_rdata  [2][2];
  logic        o_bcvalid [2];
  logic        o_bcmd    [2];
  logic [25:0] o_baddr   [2];
  logic        o_bwvalid [2];
  logic        o_bwlast  [2];
  logic [31:0] o_bwdata  [2];
  logic [3:0]  o_bwmask  [2];
  logic        o_brready [2];
  logic [1:0]  o_grant   [2];
  logic        o_busy    [2];
  logic        o_error   [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      dram_arb #(.RR_EN(gi == 0 ? 1 : 0)) u_dut (
        .clk_core          (clk_core),
        .reset_n           (reset_n),
        .m0_cvalid         (m_cvalid[0]),
        .m0_cready         (o_cready[gi][0]),
        .m0_cmd            (m_cmd[0]),
        .m0_addr           (m_addr[0]),
        .m0_wvalid         (m_wvalid[0]),
        .m0_wready         (o_wready[gi][0]),
        .m0_wlast          (m_wlast[0]),
        .m0_wdata          (m_wdata[0]),
        .m0_wmask          (m_wmask[0]),
        .m0_rvalid         (o_rvalid[gi][0]),
        .m0_rready         (m_rready[0]),
        .m0_rlast          (o_rlast[gi][0]),
        .m0_rdata          (o_rdata[gi][0]),
        .m1_cvalid         (m_cvalid[1]),
        .m1_cready         (o_cready[gi][1]),
        .m1_cmd            (m_cmd[1]),
        .m1_addr           (m_addr[1]),
        .m1_wvalid         (m_wvalid[1]),
        .m1_wready         (o_wready[gi][1]),
        .m1_wlast          (m_wlast[1]),
        .m1_wdata          (m_wdata[1]),
        .m1_wmask          (m_wmask[1]),
        .m1_rvalid         (o_rvalid[gi][1]),
        .m1_rready         (m_rready[1]),
        .m1_rlast          (o_rlast[gi][1]),
        .m1_rdata          (o_rdata[gi][1]),
        .bmain_cvalid_dctl (o_bcvalid[gi]),
        .dctl_cready       (dctl_cready),
        .bmain_cmd         (o_bcmd[gi]),
        .bmain_addr        (o_baddr[gi]),
        .bmain_wvalid_dctl (o_bwvalid[gi]),
        .dctl_wready       (dctl_wready),
        .bmain_wlast       (o_bwlast[gi]),
        .bmain_wdata       (o_bwdata[gi]),
        .bmain_wmask       (o_bwmask[gi]),
        .dctl_rvalid       (dctl_rvalid),
        .bmain_rready_dctl (o_brready[gi]),
        .dctl_rlast        (dctl_rlast),
        .dctl_rdata        (dctl_rdata),
        .arb_grant         (o_grant[gi]),
        .arb_busy          (o_busy[gi]),
        .arb_error         (o_error[gi])
      );
    end
  endgenerate

  int checks = 0;
  int errors = 0;

  task automatic cmp(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d actual=%0h required=%0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Transaction-level model: owner (-1 = none), whether its command was accepted,
  // its direction, the round-robin pointer and the sticky error flag
  int owner [2];
  bit cdone [2];
  bit isrd  [2];
  bit ptr   [2];
  bit err   [2];

  // 0 no transaction, 1 awaiting command beat, 2 write burst, 3 read burst
  function automatic int phase(input int k);
    if (owner[k] < 0) return 0;
    if (!cdone[k]) return 1;
    return isrd[k] ? 3 : 2;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      owner[k] = -1; cdone[k] = 0; isrd[k] = 0; ptr[k] = 0; err[k] = 0;
    end
  endtask

  task automatic model_step(input int k);
    int ph = phase(k);
    int g  = (owner[k] < 0) ? 0 : owner[k];
    if ((dctl_rvalid && ph != 3) || (ph == 3 && m_wvalid[g])) err[k] = 1;
    case (ph)
      0: if (m_cvalid[0] || m_cvalid[1]) begin
           if (m_cvalid[0] && m_cvalid[1]) owner[k] = (k == 0 && ptr[k]) ? 1 : 0;
           else owner[k] = m_cvalid[1] ? 1 : 0;
           cdone[k] = 0;
         end
      1: if (m_cvalid[g] && dctl_cready) begin cdone[k] = 1; isrd[k] = m_cmd[g]; end
      2: if (m_wvalid[g] && dctl_wready && m_wlast[g]) begin ptr[k] = (g == 0); owner[k] = -1; end
      3: if (dctl_rvalid && m_rready[g] && dctl_rlast) begin ptr[k] = (g == 0); owner[k] = -1; end
      default: ;
    endcase
  endtask

  task automatic compare_inst(input int k);
    int ph = phase(k);
    int g  = (owner[k] < 0) ? 0 : owner[k];
    for (int i = 0; i < 2; i++) begin
      cmp("cready", k, 64'(o_cready[k][i]), 64'((ph == 1 && g == i) ? dctl_cready : 1'b0));
      cmp("wready", k, 64'(o_wready[k][i]), 64'((ph == 2 && g == i) ? dctl_wready : 1'b0));
      cmp("rvalid", k, 64'(o_rvalid[k][i]), 64'((ph == 3 && g == i) ? dctl_rvalid : 1'b0));
      if (ph == 3) begin
        cmp("rlast", k, 64'(o_rlast[k][i]), 64'(dctl_rlast));
        cmp("rdata", k, 64'(o_rdata[k][i]), 64'(dctl_rdata));
      end
    end
    cmp("bcvalid", k, 64'(o_bcvalid[k]), 64'((ph == 1) ? m_cvalid[g] : 1'b0));
    if (ph == 1) begin
      cmp("bcmd",  k, 64'(o_bcmd[k]),  64'(m_cmd[g]));
      cmp("baddr", k, 64'(o_baddr[k]), 64'(m_addr[g]));
    end
    cmp("bwvalid", k, 64'(o_bwvalid[k]), 64'((ph == 2) ? m_wvalid[g] : 1'b0));
    cmp("bwlast",  k, 64'(o_bwlast[k]),  64'((ph == 2) ? m_wlast[g]  : 1'b0));
    cmp("bwdata",  k, 64'(o_bwdata[k]),  64'((ph == 2) ? m_wdata[g]  : 32'd0));
    cmp("bwmask",  k, 64'(o_bwmask[k]),  64'((ph == 2) ? m_wmask[g]  : 4'd0));
    cmp("brready", k, 64'(o_brready[k]), 64'((ph == 3) ? m_rready[g] : 1'b0));
    cmp("grant",   k, 64'(o_grant[k]),   64'((owner[k] < 0) ? 0 : (1 << owner[k])));
    cmp("busy",    k, 64'(o_busy[k]),    64'(owner[k] >= 0));
    cmp("error",   k, 64'(o_error[k]),   64'(err[k]));
  endtask

  // Inputs only change shortly after the rising edge, so the falling edge sees
  // exactly the values the next rising edge will sample
  always @(negedge clk_core) begin
    if (!reset_n) model_reset();
    for (int k = 0; k < 2; k++) compare_inst(k);
    if (reset_n) for (int k = 0; k < 2; k++) model_step(k);
  end

  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  task automatic clr();
    for (int i = 0; i < 2; i++) begin
      m_cvalid[i] = 0; m_cmd[i] = 0; m_addr[i] = '0; m_wvalid[i] = 0;
      m_wlast[i] = 0; m_wdata[i] = '0; m_wmask[i] = '0; m_rready[i] = 0;
    end
    dctl_cready = 0; dctl_wready = 0; dctl_rvalid = 0; dctl_rlast = 0; dctl_rdata = '0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    tick();
    tick();
    reset_n = 1;
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < 2; i++) begin
      m_cvalid[i] = ($urandom_range(0, 2) == 0);
      m_cmd[i]    = $urandom_range(0, 1) == 1;
      m_addr[i]   = 26'($urandom);
      m_wvalid[i] = ($urandom_range(0, 1) == 1);
      m_wlast[i]  = ($urandom_range(0, 3) == 0);
      m_wdata[i]  = $urandom;
      m_wmask[i]  = 4'($urandom);
      m_rready[i] = ($urandom_range(0, 3) != 0);
    end
    dctl_cready = ($urandom_range(0, 1) == 1);
    dctl_wready = ($urandom_range(0, 1) == 1);
    dctl_rvalid = (phase(0) == 3) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 59) == 0);
    dctl_rlast  = ($urandom_range(0, 3) == 0);
    dctl_rdata  = $urandom;
  endtask

  int beats;

  initial begin
    clr();
    model_reset();
    reset_n = 0;
    tick();
    tick();
    reset_n = 1;
    tick();
    for (int k = 0; k < 2; k++) begin
      cmp("rst_grant", k, 64'(o_grant[k]), 64'd0);
      cmp("rst_busy",  k, 64'(o_busy[k]),  64'd0);
      cmp("rst_error", k, 64'(o_error[k]), 64'd0);
    end

    // m0 eight-beat read
    m_cvalid[0] = 1; m_cmd[0] = 1; m_addr[0] = 26'h0000100;
    tick();
    #1;
    cmp("r36_grant",  0, 64'(o_grant[0]),   64'h1);
    cmp("r36_bcv",    0, 64'(o_bcvalid[0]), 64'h1);
    cmp("r36_baddr",  0, 64'(o_baddr[0]),   64'h100);
    cmp("r36_cready0",0, 64'(o_cready[0][0]), 64'h0);
    dctl_cready = 1;
    #1;
    cmp("r36_cready1",0, 64'(o_cready[0][0]), 64'h1);
    tick();
    m_cvalid[0] = 0; dctl_cready = 0; m_rready[0] = 1;
    beats = 0;
    for (int b = 1; b <= 8; b++) begin
      dctl_rvalid = 1; dctl_rlast = (b == 8); dctl_rdata = 32'hD000_0000 + 32'(b);
      #1;
      cmp("r36_beat_grant", 0, 64'(o_grant[0]), 64'h1);
      if (o_rvalid[0][0] && m_rready[0]) beats++;
      tick();
    end
    dctl_rvalid = 0; dctl_rlast = 0;
    #1;
    cmp("r36_beats", 0, 64'(beats), 64'd8);
    cmp("r36_idle",  0, 64'(o_busy[0]), 64'h0);
    clr();

    // Simultaneous requests: RR alternates, fixed priority keeps m0
    do_reset();
    m_cvalid[0] = 1; m_cvalid[1] = 1; m_cmd[0] = 1; m_cmd[1] = 1;
    m_rready[0] = 1; m_rready[1] = 1; dctl_cready = 1;
    tick();
    cmp("r37_first_rr", 0, 64'(o_grant[0]), 64'h1);
    cmp("r37_first_fp", 1, 64'(o_grant[1]), 64'h1);
    tick();
    dctl_rvalid = 1; dctl_rlast = 1; dctl_rdata = 32'h1111_2222;
    tick();
    dctl_rvalid = 0; dctl_rlast = 0;
    cmp("r37_gap", 0, 64'(o_busy[0]), 64'h0);
    tick();
    cmp("r37_second_rr", 0, 64'(o_grant[0]), 64'h2);
    cmp("r37_second_fp", 1, 64'(o_grant[1]), 64'h1);
    tick();
    dctl_rvalid = 1; dctl_rlast = 1;
    tick();
    clr();
    tick();

    // m1 two-beat write with downstream stall; early write data held off
    m_cvalid[1] = 1; m_cmd[1] = 0; m_addr[1] = 26'h0ABCDE; dctl_cready = 1;
    tick();
    m_wvalid[1] = 1; m_wdata[1] = 32'hA5A5_0001; m_wmask[1] = 4'hF; dctl_wready = 1;
    #1;
    cmp("r30_early_wready", 0, 64'(o_cready[0][1] ? o_wready[0][1] : o_wready[0][1]), 64'h0);
    cmp("r30_early_bwv",    0, 64'(o_bwvalid[0]), 64'h0);
    tick();
    m_cvalid[1] = 0; dctl_cready = 0; dctl_wready = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      cmp("r38_hold_data",   0, 64'(o_bwdata[0]), 64'hA5A5_0001);
      cmp("r38_hold_wready", 0, 64'(o_wready[0][1]), 64'h0);
      tick();
    end
    dctl_wready = 1;
    #1;
    cmp("r38_wready", 0, 64'(o_wready[0][1]), 64'h1);
    cmp("r38_beat1",  0, 64'(o_bwdata[0]), 64'hA5A5_0001);
    tick();
    m_wdata[1] = 32'hA5A5_0002; m_wlast[1] = 1;
    #1;
    cmp("r38_beat2", 0, 64'(o_bwdata[0]), 64'hA5A5_0002);
    tick();
    clr();
    cmp("r38_done", 0, 64'(o_busy[0]), 64'h0);
    tick();

    // m0 requests during m1's read; it waits until the rlast beat
    m_cvalid[1] = 1; m_cmd[1] = 1; dctl_cready = 1;
    tick();
    tick();
    m_cvalid[1] = 0; m_rready[1] = 1; m_cvalid[0] = 1; m_cmd[0] = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      cmp("r39_wait_cready", 0, 64'(o_cready[0][0]), 64'h0);
      cmp("r39_wait_grant",  0, 64'(o_grant[0]), 64'h2);
      tick();
    end
    dctl_rvalid = 1; dctl_rlast = 1;
    tick();
    dctl_rvalid = 0; dctl_rlast = 0;
    cmp("r39_idle", 0, 64'(o_busy[0]), 64'h0);
    cmp("r39_idle_cready", 0, 64'(o_cready[0][0]), 64'h0);
    tick();
    cmp("r39_cmd_grant", 0, 64'(o_grant[0]), 64'h1);
    cmp("r39_cmd_cready", 0, 64'(o_cready[0][0]), 64'h1);
    tick();
    m_cvalid[0] = 0; m_wvalid[0] = 1; m_wlast[0] = 1; dctl_wready = 1;
    tick();
    clr();
    tick();

    // Stray read data in IDLE sets the sticky error
    dctl_rvalid = 1;
    tick();
    dctl_rvalid = 0;
    for (int c = 0; c < 3; c++) begin
      cmp("r40_err_set", 0, 64'(o_error[0]), 64'h1);
      cmp("r40_err_set", 1, 64'(o_error[1]), 64'h1);
      tick();
    end
    reset_n = 0;
    #1;
    cmp("r40_err_clr", 0, 64'(o_error[0]), 64'h0);
    tick();
    reset_n = 1;
    tick();

    // Reset in WDATA after the pointer has moved to m1
    m_cvalid[0] = 1; m_cmd[0] = 1; dctl_cready = 1; m_rready[0] = 1;
    tick();
    tick();
    m_cvalid[0] = 0; dctl_rvalid = 1; dctl_rlast = 1;
    tick();
    dctl_rvalid = 0; dctl_rlast = 0;
    m_cvalid[0] = 1; m_cmd[0] = 0;
    tick();
    tick();
    m_cvalid[0] = 0; m_wvalid[0] = 1; m_wdata[0] = 32'hCAFE_0000; dctl_wready = 1;
    #1;
    cmp("r41_pre_wready", 0, 64'(o_wready[0][0]), 64'h1);
    reset_n = 0;
    #1;
    cmp("r41_grant",  0, 64'(o_grant[0]),    64'h0);
    cmp("r41_busy",   0, 64'(o_busy[0]),     64'h0);
    cmp("r41_bwv",    0, 64'(o_bwvalid[0]),  64'h0);
    cmp("r41_wready", 0, 64'(o_wready[0][0]), 64'h0);
    cmp("r41_bcv",    0, 64'(o_bcvalid[0]),  64'h0);
    tick();
    reset_n = 1;
    clr();
    m_cvalid[0] = 1; m_cvalid[1] = 1; m_cmd[0] = 1; m_cmd[1] = 1;
    tick();
    cmp("r41_ptr_zero", 0, 64'(o_grant[0]), 64'h1);
    clr();
    do_reset();

    // Randomized traffic with occasional resets
    for (int n = 0; n < 4000; n++) begin
      tick();
      randomize_inputs();
      reset_n = ($urandom_range(0, 299) != 0);
    end
    tick();
    clr();
    reset_n = 1;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
